// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2 iterations).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

`ifdef BOOTH_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int ITER = WIDTH / STEP;
    localparam int AW   = WIDTH + STEP;
    localparam int CW   = $clog2(ITER) + 1;
    localparam int SW   = AW + WIDTH + 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be >= 2");
    end
`ifdef BOOTH_RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("booth_mult_seq: radix-4 needs even WIDTH");
    end
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]      a_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [WIDTH-1:0]   m_q;
    logic [CW-1:0]      cnt_q;

    logic               accept;
    logic               last;
    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [SW-1:0]      shifted;

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (cnt_q == CW'(1));

    // A carries STEP guard bits so +/-M (and +/-2M) never overflow
    assign m_ext = {{STEP{m_q[WIDTH-1]}}, m_q};

`ifdef BOOTH_RADIX4_EN
    logic [AW-1:0] m_dbl;
    assign m_dbl = {m_ext[AW-2:0], 1'b0};

    always_comb begin
        addend = '0;
        unique case ({q_q[1], q_q[0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_dbl;
            3'b100:         addend = -m_dbl;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        unique case ({q_q[0], qm1_q})
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;
        endcase
    end
`endif

    assign sum     = a_q + addend;
    assign shifted = $signed({sum, q_q, qm1_q}) >>> STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else if (accept) begin
            a_q    <= '0;
            q_q    <= Q;
            qm1_q  <= 1'b0;
            m_q    <= M;
            cnt_q  <= CW'(ITER);
        end else if (state_q == S_RUN) begin
            a_q    <= shifted[SW-1:WIDTH+1];
            q_q    <= shifted[WIDTH:1];
            qm1_q  <= shifted[0];
            cnt_q  <= cnt_q - CW'(1);
            // product is captured as the last shift lands
            if (last) begin
                result <= shifted[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8.
// Build with BOOTH_RADIX4_EN defined to cover the radix-4 variant.
module tb_booth_mult_seq;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = W / 2;
`else
    localparam int ITER = W;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     M;
    logic [W-1:0]     Q;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    bit hold_en = 1'b0;
    logic [2*W-1:0] prev_res;
    logic [2*W-1:0] sb [$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .M      (M),
        .Q      (Q),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*W-1:0] prod_ref(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbb;
        sa  = $signed(a);
        sbb = $signed(b);
        return sa * sbb;
    endfunction

    // output monitor: pops the scoreboard on done, checks result hold
    always @(negedge clk) begin
        if (rst || !hold_en) begin
            prev_res = result;
        end else begin
            if (done) begin
                n_done++;
                chk("busy_done_excl", 64'(busy), 64'd0);
                if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
                else chk("product", 64'(result), 64'(sb.pop_front()));
            end else begin
                chk("result_hold", 64'(result), 64'(prev_res));
            end
            prev_res = result;
        end
    end

    task automatic run_op(input logic [W-1:0] m,
                          input logic [W-1:0] q,
                          input logic [2*W-1:0] exp);
        int n;
        @(negedge clk);
        M = m;
        Q = q;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!done) chk("busy_run", 64'(busy), 64'd1);
        end while (!done && n < 4 * ITER);
        chk("latency", 64'(n), 64'(ITER + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] corners [5];

        rst   = 1'b1;
        start = 1'b0;
        M     = '0;
        Q     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        hold_en = 1'b1;

        run_op(8'd7, 8'hFD, 16'hFFEB);
        run_op(8'h80, 8'h80, 16'h4000);
        run_op(8'h80, 8'h7F, 16'hC080);
        run_op(8'h00, 8'hFF, 16'h0000);

        corners[0] = 8'h80;
        corners[1] = 8'hFF;
        corners[2] = 8'h00;
        corners[3] = 8'h01;
        corners[4] = 8'h7F;
        foreach (corners[i]) begin
            foreach (corners[j]) begin
                run_op(corners[i], corners[j],
                       prod_ref(corners[i], corners[j]));
            end
        end

        // start pulsed mid-run with other operands must be ignored
        @(negedge clk);
        M = 8'd11;
        Q = 8'd13;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(16'd143);
        d0 = n_done;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        M = 8'h55;
        Q = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * ITER) @(negedge clk);
        chk("one_done", 64'(n_done - d0), 64'd1);

        // start held high: new operands on each done cycle
        @(negedge clk);
        a = 8'($urandom);
        b = 8'($urandom);
        M = a;
        Q = b;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(prod_ref(a, b));
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 4 * ITER);
            chk("b2b_period", 64'(n), 64'(ITER + 1));
            a = 8'($urandom);
            b = 8'($urandom);
            M = a;
            Q = b;
            @(posedge clk);
            sb.push_back(prod_ref(a, b));
        end
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 4 * ITER);
        chk("b2b_last", 64'(n), 64'(ITER + 1));

        // reset in cycle 4 of a run discards the operation
        run_op(8'd100, 8'h9C, prod_ref(8'd100, 8'h9C));
        @(negedge clk);
        M = 8'h93;
        Q = 8'h2B;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(prod_ref(8'h93, 8'h2B));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        hold_en = 1'b0;
        rst = 1'b1;
        d0 = n_done;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        hold_en = 1'b1;
        repeat (2 * ITER) @(negedge clk);
        chk("no_done_after_rst", 64'(n_done - d0), 64'd0);
        run_op(8'h81, 8'h02, prod_ref(8'h81, 8'h02));

        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, prod_ref(a, b));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential signed Booth multiplier; next generation of the fixed 4-bit controller/datapath multiplier.
- Generalises operand width and adds a start/busy/done handshake with registered result hold.
- Correct for the full signed range, including the most-negative multiplicand.
- Optional radix-4 recoding halves iteration count.
- Instantiated by the top-level as a single self-contained unit: controller FSM and A/Q/Q-1 datapath are merged.

Parameters:
- WIDTH, 8, operand width in bits (>=2; must be even when radix-4 is enabled).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE state
- M  input  WIDTH  signed multiplicand, sampled on accepted start
- Q  input  WIDTH  signed multiplier, sampled on accepted start
- busy  output  1  high while iterations are in progress
- done  output  1  one-cycle pulse: result valid and updated this cycle
- result  output  2*WIDTH  signed product; held until next completion

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-operation):
  - state=IDLE, busy=0, done=0, result=0.
  - Internal A, Q, Q-1, M and count cleared.
  - The in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch M and Q. A=0 (WIDTH+1 bits, sign-extended datapath so that A-M cannot overflow). Q-1=0. count=ITER. Go to RUN.
  - busy=1 from cycle k+1.
- RUN, one iteration per cycle:
  - Decode {Q[0],Q-1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add.
  - Then arithmetic right shift of {A,Q,Q-1} by 1, replicating the A MSB.
  - count decrements. When count reaches 1 on the final iteration, go to DONE.
- DONE (exactly one cycle):
  - result = low 2*WIDTH bits of {A,Q} after the last shift.
  - done=1, busy=0.
  - start=1 in this cycle is accepted, identical to IDLE (back-to-back throughput); otherwise go to IDLE.
- Latency:
  - ITER=WIDTH in radix-2.
  - start accepted at edge k -> done=1 and result valid during cycle k+ITER+1.
  - Throughput: one product per ITER+1 cycles.
- start while busy=1 is ignored; M and Q changes during RUN have no effect (operands are latched).
- result is stable at all times except the done cycle update; it keeps its value through IDLE and the next RUN.
- Arithmetic: result exact two's-complement product for all inputs in [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Range fits 2*WIDTH bits; maximum is (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- done and busy are never both 1.
- count width = clog2(ITER)+1.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined:
  - Radix-4 modified Booth. Decode {Q[1],Q[0],Q-1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - A widened to WIDTH+2 bits; shift of {A,Q,Q-1} is arithmetic by 2 per cycle.
  - ITER=WIDTH/2, so done arrives at cycle k+WIDTH/2+1.
  - Odd WIDTH is an elaboration error.
- Undefined: radix-2 as above. Results are identical either way; only latency differs.

Test Plan:
- WIDTH=8, radix-2: M=7, Q=-3, start at edge 0 -> busy 1..8, done=1 only at cycle 9, result=16'hFFEB (-21). Radix-4 build: done at cycle 5, same result.
- M=-128, Q=-128 -> result=16'h4000. M=-128, Q=127 -> result=16'hC080. M=0, Q=-1 -> result=0.
- start pulsed during RUN with different M/Q -> ignored; original product delivered; exactly one done pulse.
- start held high continuously with new operands presented on each done cycle -> back-to-back products every ITER+1 cycles; result changes only on done cycles.
- rst asserted at cycle 4 of a run -> next cycle busy=0, done=0, result=0; no done pulse follows; next start completes correctly.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs, plus 10k random WIDTH=16 pairs, checked against a reference product, in both macro settings.
